// File: rtl/mcp_pkg.sv
// Shared types for the multicycle MIPS memory bridge: FSM states, access targets, IR field positions.
package mcp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_IR   = 2'd1,
    T_MDR  = 2'd2
  } target_e;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned TIMER_W   = 8;

  // Strobe priority: store wins, then fetch, then load.
  function automatic target_e sel_target(input logic memwrite, input logic irwrite);
    if (memwrite)     return T_NONE;
    else if (irwrite) return T_IR;
    else              return T_MDR;
  endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// REQ-phase watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module mem_bridge_timer
  import mcp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               exp_q, exp_d;

  // expired is precomputed so it is high during the TIMEOUT-th enabled cycle
  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    if (clr_i) begin
      cnt_d = '0;
      exp_d = (TIMEOUT == 32'd1);
    end else if (en_i) begin
      cnt_d = cnt_q + TIMER_W'(1);
      exp_d = (cnt_d == TIMER_W'(TIMEOUT - 32'd1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/mem_bridge.sv
// Bridge between the multicycle MIPS controller and a req/ack memory bus; holds IR and MDR.
// Optional MEM_BRIDGE_STATS_EN adds a saturating stall_cycles counter port.
module mem_bridge
  import mcp_pkg::*;
#(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter int unsigned    TIMEOUT  = 15,
  parameter logic [DW-1:0]  IR_RESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wd,
  input  logic          memwrite,
  input  logic          irwrite,
  input  logic          memread,
  output logic          stall,
  output logic [DW-1:0] instr,
  output logic [5:0]    op,
  output logic [5:0]    funct,
  output logic [DW-1:0] data,
  output logic          err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_adr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
`ifdef MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  state_e        state_q, state_d;
  target_e       tgt_q, tgt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_adr_q, bus_adr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          timer_clr, timer_en, timer_expired;
  logic          any_strobe, conflict, misaligned;

  assign any_strobe = memwrite | irwrite | memread;
  assign conflict   = (memwrite & (irwrite | memread)) | (irwrite & memread);
  assign misaligned = |adr[1:0];

  mem_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_strobe) state_d = REQ;
      REQ:     if (bus_ack || timer_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall, bus request launch/retire and IR/MDR update
  always_comb begin
    stall       = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    tgt_d       = tgt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_adr_d   = bus_adr_q;
    bus_wdata_d = bus_wdata_q;
    instr_d     = instr_q;
    data_d      = data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (any_strobe) begin
          stall       = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = memwrite;
          bus_adr_d   = {adr[AW-1:2], 2'b00};
          bus_wdata_d = wd;
          tgt_d       = sel_target(memwrite, irwrite);
          if (conflict || misaligned) err_d = 1'b1;
        end
      end
      REQ: begin
        stall    = 1'b1;
        timer_en = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (tgt_q == T_IR)       instr_d = bus_rdata;
          else if (tgt_q == T_MDR) data_d  = bus_rdata;
        end else if (timer_expired) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          err_d     = 1'b1;
          if (tgt_q == T_IR)       instr_d = '0;
          else if (tgt_q == T_MDR) data_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_q       <= T_NONE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_adr_q   <= '0;
      bus_wdata_q <= '0;
      instr_q     <= IR_RESET;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      tgt_q       <= tgt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_adr_q   <= bus_adr_d;
      bus_wdata_q <= bus_wdata_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_adr   = bus_adr_q;
  assign bus_wdata = bus_wdata_q;
  assign instr     = instr_q;
  assign data      = data_q;
  assign err       = err_q;
  assign op        = instr_q[OP_MSB:OP_LSB];
  assign funct     = instr_q[FUNCT_MSB:FUNCT_LSB];

`ifdef MEM_BRIDGE_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
